// File: rtl/param_lock.sv
// Combination lock with programmable code, failed-attempt lockout and a
// one-second timebase for the "code saved" display and lockout countdown.
module param_lock #(
    parameter int NKEYS     = 4,
    parameter int MAXLEN    = 8,
    parameter int DEF_LEN   = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int MAX_FAIL  = 3,
    parameter int LOCKOUT_S = 10,
    parameter int DISP_S    = 3,
    localparam int KW = $clog2(NKEYS),
    localparam int IW = $clog2(MAXLEN + 1),
    localparam int FW = $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NKEYS-1:0]  key_n,
    input  logic              lever,
    output logic [2:0]        state,
    output logic              unlocked,
    output logic              alarm,
    output logic [IW-1:0]     idx,
    output logic [MAXLEN-1:0] progress,
    output logic [FW-1:0]     fail_cnt,
    output logic [7:0]        lockout_rem
);

    // state   | meaning
    // LOCKED  | collecting code digits, mismatch kept silent until the end
    // ARMED   | correct code entered, waiting for a lever rise
    // OPEN    | unlocked; key 0 enters programming
    // PROG    | collecting new code digits into the shadow buffer
    // SAVED   | new code committed, display held for DISP_S seconds
    // LOCKOUT | too many failures, all input ignored for LOCKOUT_S seconds
    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_ARMED   = 3'd1,
        S_OPEN    = 3'd2,
        S_PROG    = 3'd3,
        S_SAVED   = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLK_HZ - 1);

    state_t            st_q, st_n;
    logic [NKEYS-1:0]  k_s1, k_s2, k_s3;
    logic [NKEYS-1:0]  pulse;
    logic              press, multi;
    logic [KW-1:0]     v;
    logic              lever_q;
    logic [IW-1:0]     idx_q, idx_n, len_q, len_n;
    logic [FW-1:0]     fail_q, fail_n;
    logic              mism_q, mism_n;
    logic [7:0]        sec_q, sec_n;
    logic [TW-1:0]     tcnt;
    logic              tick, tick_clr, commit, shadow_we, do_fail;
    logic [AW-1:0]     ia;
    logic [KW-1:0]     code   [MAXLEN];
    logic [KW-1:0]     shadow [MAXLEN];

    // k_s3 holds the previous synchronised level so a release-to-press edge is one pulse
    assign pulse = k_s3 & ~k_s2;
    assign press = |pulse;
    assign multi = |(pulse & (pulse - NKEYS'(1)));
    assign ia    = AW'(idx_q);
    assign tick  = (tcnt == T_LAST);

    always_comb begin
        v = '0;
        for (int i = 0; i < NKEYS; i++)
            if (pulse[i]) v = KW'(i);
    end

    always_comb begin
        st_n      = st_q;
        idx_n     = idx_q;
        len_n     = len_q;
        fail_n    = fail_q;
        mism_n    = mism_q;
        sec_n     = sec_q;
        tick_clr  = 1'b0;
        commit    = 1'b0;
        shadow_we = 1'b0;
        do_fail   = 1'b0;
        case (st_q)
            S_LOCKED: begin
                if (idx_q == len_q) begin
                    if (mism_q) begin
                        do_fail = 1'b1;
                    end else begin
                        st_n  = S_ARMED;
                        idx_n = '0;
                    end
                end else if (lever && idx_q != '0) begin
                    do_fail = 1'b1;
                end else if (press) begin
                    if (multi || v != code[ia]) mism_n = 1'b1;
                    idx_n = idx_q + IW'(1);
                end
            end
            S_ARMED: begin
                if (press) begin
                    do_fail = 1'b1;
                end else if (lever && !lever_q) begin
                    st_n   = S_OPEN;
                    fail_n = '0;
                end
            end
            S_OPEN: begin
                if (!lever) begin
                    st_n  = S_LOCKED;
                    idx_n = '0;
                end else if (press && !multi && v == '0) begin
                    st_n  = S_PROG;
                    idx_n = '0;
                end
            end
            S_PROG: begin
                if (idx_q == IW'(MAXLEN) || (!lever && idx_q != '0)) begin
                    commit   = 1'b1;
                    len_n    = idx_q;
                    st_n     = S_SAVED;
                    idx_n    = '0;
                    sec_n    = 8'(DISP_S);
                    tick_clr = 1'b1;
                end else if (!lever) begin
                    st_n  = S_LOCKED;
                    idx_n = '0;
                end else if (press && !multi) begin
                    shadow_we = 1'b1;
                    idx_n     = idx_q + IW'(1);
                end
            end
            S_SAVED: begin
                if (tick) begin
                    sec_n = sec_q - 8'd1;
                    if (sec_q <= 8'd1) begin
                        st_n  = lever ? S_OPEN : S_LOCKED;
                        sec_n = '0;
                    end
                end
            end
            S_LOCKOUT: begin
                if (tick) begin
                    sec_n = sec_q - 8'd1;
                    if (sec_q <= 8'd1) begin
                        st_n   = S_LOCKED;
                        fail_n = '0;
                        idx_n  = '0;
                        mism_n = 1'b0;
                        sec_n  = '0;
                    end
                end
            end
            default: begin
                st_n  = S_LOCKED;
                idx_n = '0;
            end
        endcase
        // A failed attempt restarts entry; the last allowed failure enters lockout
        if (do_fail) begin
            idx_n  = '0;
            mism_n = 1'b0;
            if (fail_q >= FW'(MAX_FAIL - 1)) begin
                st_n     = S_LOCKOUT;
                fail_n   = FW'(MAX_FAIL);
                sec_n    = 8'(LOCKOUT_S);
                tick_clr = 1'b1;
            end else begin
                st_n   = S_LOCKED;
                fail_n = fail_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_s1    <= '1;
            k_s2    <= '1;
            k_s3    <= '1;
            lever_q <= 1'b0;
            st_q    <= S_LOCKED;
            idx_q   <= '0;
            len_q   <= IW'(DEF_LEN);
            fail_q  <= '0;
            mism_q  <= 1'b0;
            sec_q   <= '0;
            tcnt    <= '0;
            for (int i = 0; i < MAXLEN; i++) begin
                code[i]   <= KW'(i % NKEYS);
                shadow[i] <= '0;
            end
        end else begin
            k_s1    <= key_n;
            k_s2    <= k_s1;
            k_s3    <= k_s2;
            lever_q <= lever;
            st_q    <= st_n;
            idx_q   <= idx_n;
            len_q   <= len_n;
            fail_q  <= fail_n;
            mism_q  <= mism_n;
            sec_q   <= sec_n;
            if (tick_clr || tick) tcnt <= '0;
            else                  tcnt <= tcnt + TW'(1);
            if (commit)
                for (int i = 0; i < MAXLEN; i++) code[i] <= shadow[i];
            if (shadow_we) shadow[ia] <= v;
        end
    end

    assign state       = st_q;
    assign unlocked    = (st_q == S_OPEN) || (st_q == S_PROG);
    assign alarm       = (st_q == S_LOCKOUT);
    assign idx         = idx_q;
    assign fail_cnt    = fail_q;
    assign lockout_rem = (st_q == S_LOCKOUT) ? sec_q : 8'd0;

    always_comb begin
        progress = '0;
        for (int i = 0; i < MAXLEN; i++)
            progress[i] = (int'(idx_q) > i);
    end

endmodule

// File: tb/tb_param_lock.sv
// Scoreboard bench for param_lock: a list-based lock model predicts every
// visible output change; a negedge monitor pops and compares each change.
module tb_param_lock;
    localparam int NK = 4, ML = 8, DL = 4, HZ = 10, MF = 3, LS = 5, DS = 3;
    localparam int IW = $clog2(ML + 1);
    localparam int FW = $clog2(MF + 1);
    localparam int SW = 3 + IW + FW + 8 + 2 + ML;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] key_n;
    logic          lever;
    logic [2:0]    state;
    logic          unlocked, alarm;
    logic [IW-1:0] idx;
    logic [ML-1:0] progress;
    logic [FW-1:0] fail_cnt;
    logic [7:0]    lockout_rem;

    param_lock #(.NKEYS(NK), .MAXLEN(ML), .DEF_LEN(DL), .CLK_HZ(HZ),
                 .MAX_FAIL(MF), .LOCKOUT_S(LS), .DISP_S(DS)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .lever(lever), .state(state),
        .unlocked(unlocked), .alarm(alarm), .idx(idx), .progress(progress),
        .fail_cnt(fail_cnt), .lockout_rem(lockout_rem));

    always #5 clk = ~clk;

    typedef struct {int st; int idx; int fail; int rem; int dwell;} exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, ev_no = 0;

    // Model: state code, code list, digits entered so far, new-code buffer
    int m_st, m_fail, m_len;
    int m_code[ML];
    int m_ent[$];
    int m_shd[$];
    bit m_lever;

    function automatic void expect_ev(int st, int ix, int fl, int rem, int dwell);
        exp_t e;
        e.st = st; e.idx = ix; e.fail = fl; e.rem = rem; e.dwell = dwell;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        m_st = 0; m_fail = 0; m_len = DL;
        for (int i = 0; i < ML; i++) m_code[i] = i % NK;
        m_ent.delete();
        m_shd.delete();
    endfunction

    function automatic void fail_attempt(int dwell);
        m_ent.delete();
        m_fail++;
        if (m_fail >= MF) begin
            m_fail = MF;
            m_st = 5;
            expect_ev(5, 0, MF, LS, dwell);
            for (int r = LS - 1; r >= 0; r--)
                expect_ev(r > 0 ? 5 : 0, 0, r > 0 ? MF : 0, r, HZ);
        end else begin
            m_st = 0;
            expect_ev(0, 0, m_fail, 0, dwell);
        end
    endfunction

    function automatic void commit(int dwell);
        m_len = m_shd.size();
        for (int i = 0; i < m_len; i++) m_code[i] = m_shd[i];
        m_shd.delete();
        m_st = 4;
        expect_ev(4, -1, m_fail, 0, dwell);
        expect_ev(m_lever ? 2 : 0, m_lever ? -1 : 0, m_fail, 0, DS * HZ);
    endfunction

    function automatic void model_press(int v);
        bit ok;
        case (m_st)
            0: begin
                m_ent.push_back(v);
                expect_ev(0, m_ent.size(), m_fail, 0, -1);
                if (m_ent.size() == m_len) begin
                    ok = 1;
                    for (int i = 0; i < m_len; i++)
                        if (m_ent[i] != m_code[i]) ok = 0;
                    if (ok) begin
                        m_ent.delete();
                        m_st = 1;
                        expect_ev(1, -1, m_fail, 0, 1);
                    end else begin
                        fail_attempt(1);
                    end
                end else if (m_lever) begin
                    fail_attempt(1);
                end
            end
            1: fail_attempt(-1);
            2: if (v == 0) begin
                m_st = 3;
                m_shd.delete();
                expect_ev(3, 0, m_fail, 0, -1);
            end
            3: if (v >= 0) begin
                m_shd.push_back(v);
                expect_ev(3, m_shd.size(), m_fail, 0, -1);
                if (m_shd.size() == ML) commit(1);
            end
            default: ;
        endcase
    endfunction

    function automatic void model_lever(bit b);
        bit old;
        old = m_lever;
        m_lever = b;
        if (old == b) return;
        case (m_st)
            0: if (b && m_ent.size() > 0) fail_attempt(-1);
            1: if (b) begin m_st = 2; m_fail = 0; expect_ev(2, -1, 0, 0, -1); end
            2: if (!b) begin m_st = 0; expect_ev(0, 0, m_fail, 0, -1); end
            3: if (!b) begin
                if (m_shd.size() > 0) commit(-1);
                else begin m_st = 0; expect_ev(0, 0, m_fail, 0, -1); end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [ML-1:0] therm(int n);
        logic [ML-1:0] t;
        t = '0;
        for (int i = 0; i < ML; i++) if (i < n) t[i] = 1'b1;
        return t;
    endfunction

    task automatic press_mask(input logic [NK-1:0] m);
        int v;
        v = -1;
        if ($countones(m) == 1)
            for (int i = 0; i < NK; i++) if (m[i]) v = i;
        model_press(v);
        @(posedge clk); #1 key_n = ~m;
        repeat (3) @(posedge clk);
        #1 key_n = '1;
        repeat (3) @(posedge clk);
    endtask

    task automatic set_lever(input bit b);
        model_lever(b);
        @(posedge clk); #1 lever = b;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL settle_timeout: %0d expected events pending, required 0", sb.size());
            sb.delete();
        end
        if (m_st == 5) begin m_st = 0; m_fail = 0; end
        else if (m_st == 4) m_st = m_lever ? 2 : 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic key(input int k);
        press_mask(NK'(1) << k);
        settle();
    endtask

    task automatic multi_key();
        logic [NK-1:0] m;
        m = NK'($urandom);
        while ($countones(m) < 2) m = NK'($urandom);
        press_mask(m);
        settle();
    endtask

    task automatic lev(input bit b);
        set_lever(b);
        settle();
    endtask

    task automatic check_event(input int dwell);
        exp_t e;
        bit ok;
        ev_no++;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event%0d: state=%0d idx=%0d fail_cnt=%0d rem=%0d, required no change",
                     ev_no, state, idx, fail_cnt, lockout_rem);
            return;
        end
        e = sb.pop_front();
        ok = (state == e.st) && (fail_cnt == e.fail) && (lockout_rem == e.rem) &&
             (unlocked == (e.st == 2 || e.st == 3)) && (alarm == (e.st == 5)) &&
             (e.idx < 0 || (idx == e.idx && progress == therm(e.idx))) &&
             (e.dwell < 0 || dwell == e.dwell);
        if (!ok) begin
            failures++;
            $display("FAIL event%0d: state=%0d idx=%0d fail_cnt=%0d rem=%0d unlocked=%0d alarm=%0d progress=%b dwell=%0d, required state=%0d idx=%0d fail_cnt=%0d rem=%0d dwell=%0d",
                     ev_no, state, idx, fail_cnt, lockout_rem, unlocked, alarm, progress, dwell,
                     e.st, e.idx, e.fail, e.rem, e.dwell);
        end
    endtask

    initial begin
        logic [SW-1:0] snap, prev;
        bit first;
        int cyc, last;
        first = 1; cyc = 0; last = 0; prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            snap = {state, idx, fail_cnt, lockout_rem, unlocked, alarm, progress};
            if (first || snap !== prev) begin
                check_event(first ? -1 : cyc - last);
                first = 0;
                last = cyc;
                prev = snap;
            end
        end
    end

    task automatic random_step();
        int r;
        r = $urandom_range(0, 99);
        case (m_st)
            0: begin
                if (m_lever) begin
                    if (r < 70) lev(0); else key($urandom_range(0, NK - 1));
                end else if (r < 8) lev(1);
                else if (r < 14) multi_key();
                else if (r < 65) key(m_code[m_ent.size()]);
                else key($urandom_range(0, NK - 1));
            end
            1: begin
                if (m_lever) lev(0);
                else if (r < 75) lev(1);
                else key($urandom_range(0, NK - 1));
            end
            2: begin
                if (r < 35) key(0);
                else if (r < 55) key($urandom_range(1, NK - 1));
                else if (r < 65) multi_key();
                else lev(0);
            end
            3: begin
                if (r < 70) key($urandom_range(0, NK - 1));
                else if (r < 80) multi_key();
                else lev(0);
            end
            default: settle();
        endcase
    endtask

    initial begin
        key_n = '1;
        lever = 1'b0;
        m_lever = 0;
        model_reset();
        expect_ev(0, 0, 0, 0, -1);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        settle();

        // default code opens
        key(0); key(1); key(2); key(3); lev(1); lev(0);

        // three wrong attempts; inputs during lockout are ignored
        for (int a = 0; a < 3; a++) begin
            key(0); key(3); key(2);
            if (a < 2) key(3);
            else begin
                press_mask(4'b1000);
                repeat (10) @(posedge clk);
                press_mask(4'b0001);
                set_lever(1);
                repeat (5) @(posedge clk);
                set_lever(0);
                settle();
            end
        end

        // two keys at once on the first digit is a mismatch
        press_mask(4'b0110); settle();
        key(1); key(2); key(3);
        key(0); key(1); key(2); key(3); lev(1);

        // program 3,3,1 via lever low, then use it
        key(0); key(3); key(3); key(1); lev(0);
        key(3); key(3); key(1); lev(1); lev(0);
        key(0); key(1); key(2); key(3); key(3); key(1); lev(1);

        // PROG with no digits leaves the code unchanged
        key(0); lev(0);
        key(3); key(3); key(1); lev(1);

        // invalid press in PROG ignored, then 8 digits auto-commit with lever high
        key(0); press_mask(4'b0101); settle();
        for (int i = 0; i < ML; i++) key($urandom_range(0, NK - 1));
        key(2); lev(0);
        for (int i = 0; i < ML; i++) key(m_code[i]);
        lev(1);

        // reset in PROG restores the default code
        key(0); key(1); key(2);
        expect_ev(0, 0, 0, 0, -1);
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 lever = 1'b0;
        m_lever = 0;
        @(posedge clk); #1 rst = 1'b0;
        settle();
        key(0); key(1); key(2); key(3); lev(1); lev(0);

        for (int i = 0; i < 150; i++) random_step();
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
